// File: rtl/pea_pkg.sv
// pea_pkg: shared definitions for the Polynomial Evaluation Accelerator core.
//   Mode encodings sampled with invoke, opcodes, status codes, FSM states,
//   and polynomial storage limits.
package pea_pkg;

   localparam int NUM_POLY   = 8;
   localparam int MAX_DEGREE = 10;
   localparam int DEG_W      = 4;   // holds 0..MAX_DEGREE

   typedef enum logic [1:0] {
      MODE_SETUP_INSTR = 2'b00,
      MODE_INSTR       = 2'b01,
      MODE_OUTPUT      = 2'b10
   } pea_mode_e;

   localparam logic [7:0] OP_STP = 8'h01;
   localparam logic [7:0] OP_EVP = 8'h02;
   localparam logic [7:0] OP_RST = 8'h03;

   localparam logic [1:0] ST_OK     = 2'd0;
   localparam logic [1:0] ST_BAD_OP = 2'd1;
   localparam logic [1:0] ST_UNDEF  = 2'd2;
   localparam logic [1:0] ST_DEG    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GC_POP,
      S_GC_DECODE,
      S_EXEC,
      S_EVAL,
      S_OUT_WR,
      S_DONE
   } pea_state_e;

endpackage

// File: rtl/pea_horner.sv
// pea_horner: sequential Horner evaluator, one step per cycle.
//   start    : load acc with c_deg and latch x (caller pops x that cycle)
//   x_in     : evaluation point, signed
//   deg_in   : polynomial degree
//   coef_in  : coefficient addressed by coef_idx (combinational read port)
//   coef_idx : index of the coefficient needed this cycle
//   last     : the final accumulator update happens at the coming edge
//   acc_nxt  : value the accumulator takes at the coming edge
module pea_horner
   import pea_pkg::*;
#(
   parameter int CW   = 16,
   parameter int ACCW = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic signed [CW-1:0]   x_in,
   input  logic [DEG_W-1:0]       deg_in,
   input  logic signed [CW-1:0]   coef_in,
   output logic [DEG_W-1:0]       coef_idx,
   output logic                   last,
   output logic [ACCW-1:0]        acc_nxt
);

   logic [ACCW-1:0]  acc_q, acc_d, x_q, x_d;
   logic [DEG_W-1:0] cnt_q, cnt_d;   // Horner steps still to run
   logic             busy;

   assign busy     = (cnt_q != '0);
   // While idle the port points at the leading coefficient so start can load it.
   assign coef_idx = busy ? cnt_q - DEG_W'(1) : deg_in;
   assign acc_nxt  = acc_d;

   always_comb begin
      acc_d = acc_q;
      x_d   = x_q;
      cnt_d = cnt_q;
      last  = 1'b0;
      if (start) begin
         acc_d = ACCW'(coef_in);   // sign-extending cast
         x_d   = ACCW'(x_in);
         cnt_d = deg_in;
         last  = (deg_in == '0);
      end else if (busy) begin
         // Low 32 bits of the product are sign-agnostic, so plain * suffices.
         acc_d = acc_q * x_q + ACCW'(coef_in);
         cnt_d = cnt_q - DEG_W'(1);
         last  = (cnt_q == DEG_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         x_q   <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         x_q   <= x_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pea_core.sv
// pea_core: PEA controller and datapath (CFDF actor with three modes).
//   clk, rst                 : clock, async active-low reset
//   command_in / data_in     : heads of the command / data input FIFOs
//   command_count/data_count : FIFO populations
//   invoke, next_mode_in     : fire request and mode (SETUP_INSTR/INSTR/OUTPUT)
//   rd_in_command/rd_in_data : FIFO pop strobes
//   FC                       : firing-complete pulse
//   wr_out, data_out_*       : output FIFO push with result and status words
//   instr, arg2              : decoded command fields for the enable block
//   wr_addr_command          : commands consumed; rd_addr_command: commands retired
module pea_core
   import pea_pkg::*;
#(
   parameter  int BUFFER_SIZE = 1024,
   parameter  int WIDTH       = 16,
   parameter  int OUT_WIDTH   = 32,
   localparam int AW          = $clog2(BUFFER_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     command_in,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 invoke,
   input  logic [1:0]           next_mode_in,
   input  logic [AW-1:0]        data_count,
   input  logic [AW-1:0]        command_count,
   output logic                 rd_in_command,
   output logic                 rd_in_data,
   output logic                 FC,
   output logic                 wr_out,
   output logic [OUT_WIDTH-1:0] data_out_result,
   output logic [OUT_WIDTH-1:0] data_out_status,
   output logic [7:0]           instr,
   output logic [4:0]           arg2,
   output logic [AW-1:0]        wr_addr_command,
   output logic [AW-1:0]        rd_addr_command
);

   pea_state_e                     state_q, state_d;
   logic [WIDTH-1:0]               cmd_q, cmd_d;
   logic [7:0]                     instr_q, instr_d;
   logic [2:0]                     arg1_q, arg1_d;
   logic [4:0]                     arg2_q, arg2_d;
   logic [AW-1:0]                  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DEG_W-1:0]               cnt_q, cnt_d;      // STP coefficient index
   logic [NUM_POLY-1:0]            valid_q, valid_d;
   logic [NUM_POLY-1:0][DEG_W-1:0] deg_q, deg_d;
   logic [OUT_WIDTH-1:0]           res_q, res_d, stat_q, stat_d;
   logic [OUT_WIDTH-1:0]           dres_q, dres_d, dstat_q, dstat_d;

   logic signed [WIDTH-1:0]        coef_mem [NUM_POLY][MAX_DEGREE+1];

   logic                           coef_we, pop_data, h_start, h_last;
   logic [DEG_W-1:0]               h_idx;
   logic [OUT_WIDTH-1:0]           h_acc_nxt;
   logic signed [WIDTH-1:0]        h_coef;

   assign h_coef = coef_mem[arg1_q][h_idx];

   pea_horner #(.CW(WIDTH), .ACCW(OUT_WIDTH)) u_horner (
      .clk      (clk),
      .rst      (rst),
      .start    (h_start),
      .x_in     (data_in),
      .deg_in   (deg_q[arg1_q]),
      .coef_in  (h_coef),
      .coef_idx (h_idx),
      .last     (h_last),
      .acc_nxt  (h_acc_nxt)
   );

   // Pop strobes are decoded from the current state and FIFO count so a pop
   // lines up with the head word the FIFO presents in the same cycle.
   assign rd_in_command   = (state_q == S_GC_POP) && (command_count != '0);
   assign rd_in_data      = pop_data;
   assign FC              = (state_q == S_DONE);
   assign wr_out          = (state_q == S_OUT_WR);
   assign data_out_result = dres_q;
   assign data_out_status = dstat_q;
   assign instr           = instr_q;
   assign arg2            = arg2_q;
   assign wr_addr_command = wr_addr_q;
   assign rd_addr_command = rd_addr_q;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      instr_d   = instr_q;
      arg1_d    = arg1_q;
      arg2_d    = arg2_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      deg_d     = deg_q;
      res_d     = res_q;
      stat_d    = stat_q;
      dres_d    = dres_q;
      dstat_d   = dstat_q;
      coef_we   = 1'b0;
      pop_data  = 1'b0;
      h_start   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Reserved mode 2'b11 is not fired.
            if (invoke) begin
               case (next_mode_in)
                  MODE_SETUP_INSTR: state_d = S_GC_POP;
                  MODE_INSTR: begin
                     state_d = S_EXEC;
                     cnt_d   = '0;
                  end
                  MODE_OUTPUT: begin
                     state_d   = S_OUT_WR;
                     dres_d    = res_q;
                     dstat_d   = stat_q;
                     rd_addr_d = rd_addr_q + 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_GC_POP: begin
            if (command_count != '0) begin
               cmd_d   = command_in;
               state_d = S_GC_DECODE;
            end
         end
         S_GC_DECODE: begin
            instr_d   = cmd_q[15:8];
            arg1_d    = cmd_q[7:5];
            arg2_d    = cmd_q[4:0];
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = S_DONE;
         end
         S_EXEC: begin
            case (instr_q)
               OP_STP: begin
                  if (arg2_q > 5'(MAX_DEGREE)) begin
                     stat_d  = OUT_WIDTH'(ST_DEG);
                     state_d = S_DONE;
                  end else if (data_count != '0) begin
                     pop_data = 1'b1;
                     coef_we  = 1'b1;
                     cnt_d    = cnt_q + 1'b1;
                     if (cnt_q == arg2_q[DEG_W-1:0]) begin
                        valid_d[arg1_q] = 1'b1;
                        deg_d[arg1_q]   = arg2_q[DEG_W-1:0];
                        stat_d          = OUT_WIDTH'(ST_OK);
                        state_d         = S_DONE;
                     end
                  end
               end
               OP_EVP: begin
                  if (!valid_q[arg1_q]) begin
                     res_d   = '0;
                     stat_d  = OUT_WIDTH'(ST_UNDEF);
                     state_d = S_DONE;
                  end else if (data_count != '0) begin
                     pop_data = 1'b1;
                     h_start  = 1'b1;
                     stat_d   = OUT_WIDTH'(ST_OK);
                     if (h_last) begin
                        res_d   = h_acc_nxt;   // degree-0: result is c0
                        state_d = S_DONE;
                     end else begin
                        state_d = S_EVAL;
                     end
                  end
               end
               OP_RST: begin
                  valid_d = '0;
                  res_d   = '0;
                  stat_d  = OUT_WIDTH'(ST_OK);
                  state_d = S_DONE;
               end
               default: begin
                  stat_d  = OUT_WIDTH'(ST_BAD_OP);
                  state_d = S_DONE;
               end
            endcase
         end
         S_EVAL: begin
            if (h_last) begin
               res_d   = h_acc_nxt;
               state_d = S_DONE;
            end
         end
         S_OUT_WR: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         instr_q   <= '0;
         arg1_q    <= '0;
         arg2_q    <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         cnt_q     <= '0;
         valid_q   <= '0;
         deg_q     <= '0;
         res_q     <= '0;
         stat_q    <= '0;
         dres_q    <= '0;
         dstat_q   <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         instr_q   <= instr_d;
         arg1_q    <= arg1_d;
         arg2_q    <= arg2_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         deg_q     <= deg_d;
         res_q     <= res_d;
         stat_q    <= stat_d;
         dres_q    <= dres_d;
         dstat_q   <= dstat_d;
      end
   end

   // Coefficient storage needs no reset: slot validity gates every read.
   always_ff @(posedge clk) begin
      if (coef_we) coef_mem[arg1_q][cnt_q] <= data_in;
   end

endmodule

// File: tb/tb_pea_core.sv
module tb_pea_core;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   command_in, data_in;
   logic          invoke;
   logic [1:0]    next_mode_in;
   logic [AW-1:0] data_count, command_count;
   logic          rd_in_command, rd_in_data, FC, wr_out;
   logic [31:0]   data_out_result, data_out_status;
   logic [7:0]    instr;
   logic [4:0]    arg2;
   logic [AW-1:0] wr_addr_command, rd_addr_command;

   pea_core dut (
      .clk(clk), .rst(rst), .command_in(command_in), .data_in(data_in),
      .invoke(invoke), .next_mode_in(next_mode_in), .data_count(data_count),
      .command_count(command_count), .rd_in_command(rd_in_command),
      .rd_in_data(rd_in_data), .FC(FC), .wr_out(wr_out),
      .data_out_result(data_out_result), .data_out_status(data_out_status),
      .instr(instr), .arg2(arg2), .wr_addr_command(wr_addr_command),
      .rd_addr_command(rd_addr_command)
   );

   always #5 clk = ~clk;

   // External FIFOs and the reference model state.
   logic [15:0] cq[$], dq[$], stim[$];
   int          cmd_pops = 0, data_pops = 0;
   int          n_chk = 0, n_err = 0;
   logic [15:0] m_coef [8][11];
   int          m_deg [8];
   bit  [7:0]   m_valid;
   logic [31:0] m_res, m_stat;
   int          m_wr, m_rd;

   // FIFO emulation: strobes sampled mid-cycle, popped just after the edge.
   always begin
      logic pc, pd;
      @(negedge clk);
      pc = rd_in_command;
      pd = rd_in_data;
      @(posedge clk);
      #1;
      if (pc && cq.size() > 0) begin void'(cq.pop_front()); cmd_pops++; end
      if (pd && dq.size() > 0) begin void'(dq.pop_front()); data_pops++; end
      command_in    = (cq.size() > 0) ? cq[0] : 16'h0;
      data_in       = (dq.size() > 0) ? dq[0] : 16'h0;
      command_count = AW'(cq.size());
      data_count    = AW'(dq.size());
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // p(x) = sum c_i * x^i, modulo 2^32
   function automatic logic [31:0] poly_val(input int slot, input logic [15:0] x);
      logic [31:0] sum = 0, pw = 1, xs;
      xs = {{16{x[15]}}, x};
      for (int i = 0; i <= m_deg[slot]; i++) begin
         sum = sum + {{16{m_coef[slot][i][15]}}, m_coef[slot][i]} * pw;
         pw  = pw * xs;
      end
      return sum;
   endfunction

   task automatic start_fire(input logic [1:0] mode);
      @(negedge clk);
      invoke = 1'b1;
      next_mode_in = mode;
      @(posedge clk);
      #1 invoke = 1'b0;
   endtask

   // cyc = negedges after the invoke edge up to and including FC
   task automatic wait_fc(output int cyc, output int nwr, output logic [31:0] r, output logic [31:0] s);
      cyc = 0; nwr = 0; r = 0; s = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (wr_out) begin nwr++; r = data_out_result; s = data_out_status; end
      end while (!FC && cyc < 100);
      chk("fc_seen", FC, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {FC, wr_out, rd_in_command, rd_in_data, instr, arg2}, 0);
      chk({tag, "_cnt"}, {wr_addr_command, rd_addr_command}, 0);
      chk({tag, "_res"}, data_out_result, 0);
      chk({tag, "_stat"}, data_out_status, 0);
   endtask

   // Full SETUP_INSTR + INSTR pair; data words come from stim.
   task automatic do_cmd(input logic [15:0] cmd);
      logic [7:0]  op;
      int          a1, a2, c0, d0, cyc, nwr, exp_pops, exp_lat;
      logic [31:0] r, s;
      op = cmd[15:8]; a1 = int'(cmd[7:5]); a2 = int'(cmd[4:0]);
      cq.push_back(cmd);
      c0 = cmd_pops;
      start_fire(2'b00);
      wait_fc(cyc, nwr, r, s);
      m_wr = (m_wr + 1) % 1024;
      chk("gc_lat", cyc, 3);
      chk("gc_pops", cmd_pops - c0, 1);
      chk("instr", instr, op);
      chk("arg2", arg2, a2);
      chk("wr_addr", wr_addr_command, m_wr);
      exp_pops = 0; exp_lat = 2;
      case (op)
         8'h01: if (a2 > 10) m_stat = 3;
                else begin
                   for (int i = 0; i <= a2; i++) m_coef[a1][i] = stim[i];
                   m_deg[a1] = a2; m_valid[a1] = 1'b1; m_stat = 0;
                   exp_pops = a2 + 1; exp_lat = a2 + 2;
                end
         8'h02: if (!m_valid[a1]) begin m_res = 0; m_stat = 2; end
                else begin
                   m_res = poly_val(a1, stim[0]); m_stat = 0;
                   exp_pops = 1; exp_lat = m_deg[a1] + 2;
                end
         8'h03: begin m_valid = '0; m_res = 0; m_stat = 0; end
         default: m_stat = 1;
      endcase
      foreach (stim[i]) dq.push_back(stim[i]);
      d0 = data_pops;
      start_fire(2'b01);
      wait_fc(cyc, nwr, r, s);
      chk("ex_lat", cyc, exp_lat);
      chk("ex_pops", data_pops - d0, exp_pops);
      chk("ex_nowr", nwr, 0);
      dq.delete();
      stim.delete();
   endtask

   task automatic do_out();
      int cyc, nwr;
      logic [31:0] r, s;
      start_fire(2'b10);
      wait_fc(cyc, nwr, r, s);
      m_rd = (m_rd + 1) % 1024;
      chk("out_lat", cyc, 2);
      chk("out_wr", nwr, 1);
      chk("result", r, m_res);
      chk("status", s, m_stat);
      chk("rd_addr", rd_addr_command, m_rd);
   endtask

   initial begin
      int cyc, nwr, d0, nfc, k;
      logic [31:0] r, s;
      logic [7:0]  op;
      logic [2:0]  a1;
      logic [4:0]  a2;

      rst = 1'b0; invoke = 1'b0; next_mode_in = 2'b00;
      command_in = '0; data_in = '0; data_count = '0; command_count = '0;
      m_valid = '0; m_res = 0; m_stat = 0; m_wr = 0; m_rd = 0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;

      // Plan 1-2: STP slot 0 = 3 + 2x + x^2, then EVP at x=2 -> 11
      stim = '{16'd3, 16'd2, 16'd1};
      do_cmd(16'h0102);
      chk("rd_addr_init", rd_addr_command, 0);
      stim = '{16'd2};
      do_cmd(16'h0200);
      do_out();
      chk("p2_result", m_res, 11);
      // Plan 3: EVP on unset slot 7 (decoy word present)
      stim = '{16'h1234};
      do_cmd(16'h02E0); do_out();
      // Plan 4: bad opcode
      stim = '{16'h1234};
      do_cmd(16'h0F00); do_out();
      // Plan 5: degree too large, then RST and EVP on slot 0
      stim = '{16'h1234};
      do_cmd(16'h010C); do_out();
      stim = '{16'h1234};
      do_cmd(16'h0300); do_out();
      stim = '{16'h1234};
      do_cmd(16'h0200); do_out();

      // Stall: EVP with an empty data FIFO waits without popping
      stim = '{16'd3, 16'd2, 16'd1};
      do_cmd(16'h0102);
      cq.push_back(16'h0200);
      start_fire(2'b00);
      wait_fc(cyc, nwr, r, s);
      m_wr = (m_wr + 1) % 1024;
      d0 = data_pops; nfc = 0;
      start_fire(2'b01);
      repeat (6) begin @(negedge clk); nfc += int'(FC); end
      chk("stall_fc", nfc, 0);
      chk("stall_pops", data_pops - d0, 0);
      dq.push_back(16'd5);
      wait_fc(cyc, nwr, r, s);
      chk("stall_pop1", data_pops - d0, 1);
      m_res = poly_val(0, 16'd5); m_stat = 0;
      do_out();

      // Randomized command stream
      for (int it = 0; it < 60; it++) begin
         k  = $urandom_range(0, 9);
         a1 = 3'($urandom);
         a2 = 5'($urandom);
         if (k < 4) begin
            op = 8'h01;
            if ($urandom_range(0, 7) != 0) a2 = 5'($urandom_range(0, 10));
            else a2 = 5'($urandom_range(11, 31));
         end else if (k < 8) op = 8'h02;
         else if (k == 8)    op = 8'h03;
         else                op = 8'($urandom_range(4, 255));
         if (op == 8'h01 && a2 <= 5'd10)
            for (int i = 0; i <= int'(a2); i++) stim.push_back(16'($urandom));
         else
            stim.push_back(16'($urandom));
         do_cmd({op, a1, a2});
         if ($urandom_range(0, 1) == 1) do_out();
      end
      do_out();

      // Plan 6: reset in the middle of a degree-10 evaluation
      for (int i = 0; i <= 10; i++) stim.push_back(16'($urandom));
      do_cmd(16'h012A);
      cq.push_back(16'h0220);
      start_fire(2'b00);
      wait_fc(cyc, nwr, r, s);
      dq.push_back(16'd3);
      start_fire(2'b01);
      repeat (4) @(negedge clk);
      chk("mid_eval_nofc", FC, 0);
      rst = 1'b0;
      #1;
      chk_zero("mid_rst");
      repeat (2) @(negedge clk);
      cq.delete(); dq.delete(); stim.delete();
      m_valid = '0; m_res = 0; m_stat = 0; m_wr = 0; m_rd = 0;
      @(negedge clk);
      rst = 1'b1;
      stim = '{16'd3, 16'd2, 16'd1};
      do_cmd(16'h0102);
      stim = '{16'd7};
      do_cmd(16'h0220);
      do_out();
      chk("post_rst_stat", m_stat, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pea_core.md
Name: pea_core

Overview:
Core controller and datapath of the Polynomial Evaluation Accelerator (PEA), a CFDF actor with three modes.
- It pulls commands and data from two external input FIFOs and stores up to 8 polynomials.
- It evaluates a stored polynomial by Horner's rule.
- It pushes one result word and one status word per evaluation into two external output FIFOs.
- An external enable block reads its decoded instr/arg2 and command counters to decide when it may fire.

Parameters:
BUFFER_SIZE, 1024, depth of the input FIFOs; the pop-count and address width is AW = log2(BUFFER_SIZE) = 10.
WIDTH, 16, width of command and data words.
OUT_WIDTH, 32, width of result and status words.
NUM_POLY, 8, number of polynomial slots.
MAX_DEGREE, 10, highest degree accepted.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
command_in  in  WIDTH  head word of the command FIFO, valid combinationally.
data_in  in  WIDTH  head word of the data FIFO, signed, valid combinationally.
invoke  in  1  one-cycle fire request.
next_mode_in  in  2  mode sampled with invoke: 00 SETUP_INSTR, 01 INSTR, 10 OUTPUT.
data_count  in  AW  population of the data FIFO.
command_count  in  AW  population of the command FIFO.
rd_in_command  out  1  pop strobe to the command FIFO.
rd_in_data  out  1  pop strobe to the data FIFO.
FC  out  1  firing complete, one-cycle pulse.
wr_out  out  1  push strobe to both output FIFOs.
data_out_result  out  OUT_WIDTH  result word.
data_out_status  out  OUT_WIDTH  status word.
instr  out  8  decoded opcode.
arg2  out  5  decoded argument 2.
wr_addr_command  out  AW  count of command words consumed, mod 2^AW.
rd_addr_command  out  AW  count of commands fully retired, mod 2^AW.

Behaviour:
- Reset (async, rst=0): all outputs 0, FSM in IDLE, all polynomial slots invalid, counters 0.
- FSM states: IDLE, GC_POP, GC_DECODE, EXEC, EVAL, OUT_WR, DONE.
- In IDLE, invoke=1 is required to start a firing. invoke while busy is ignored.

SETUP_INSTR (get command):
- Cycle 1: GC_POP drives rd_in_command=1 and latches command_in.
- Cycle 2: GC_DECODE sets instr=cmd[15:8], arg1=cmd[7:5], arg2=cmd[4:0] and increments wr_addr_command.
- Cycle 3: DONE pulses FC.
- instr and arg2 hold until the next decode.

INSTR:
- 0x01 STP: pops arg2+1 data words, one per cycle, c0 first, into slot arg1, then marks the slot valid with degree=arg2.
  - If arg2>MAX_DEGREE: no pops, status=3.
- 0x02 EVP: pops one x and evaluates with a 32-bit accumulator: acc=c_N, then acc=acc*x+c_i for i=N-1..0.
  - One Horner step per cycle; sign-extended; truncated to 32 bits.
  - If slot arg1 is invalid: no pop, result 0, status=2.
- 0x03 RST: invalidates all slots, result 0, status 0.
- Any other opcode: status=1, no pops.
- FC pulses the cycle after the last pop or Horner step.
- The core never pops an empty FIFO. The enable block guarantees counts; if a count is 0 the core stalls in EXEC with no pop.

OUTPUT:
- Drives wr_out=1 for one cycle with data_out_result=latest result and data_out_status=latest status (0 = OK).
- Increments rd_addr_command, then FC next cycle.

Other rules:
- Counters wrap at 2^AW.
- If invoke and rst coincide, reset wins.

Decomposition:
- Package pea_pkg holds: mode encodings (SETUP_INSTR/INSTR/OUTPUT), opcodes (STP=0x01, EVP=0x02, RST=0x03), status codes (0 OK, 1 bad opcode, 2 undefined poly, 3 degree too large), FSM state enum, MAX_DEGREE, NUM_POLY.
- One sub-module, pea_horner, is natural: the sequential Horner evaluator with start/done and the coefficient read port. The coefficient memory and FSM stay in pea_core.

Test Plan:
1. Reset, then push command 0x0102 and invoke SETUP_INSTR -> one rd_in_command pulse; FC on 3rd cycle; instr=1, arg2=2; wr_addr_command=1, rd_addr_command=0.
2. After test 1, data 3,2,1, invoke INSTR -> three rd_in_data pulses, FC; then command 0x0200 with data x=2, through GC/INSTR/OUTPUT -> wr_out once, result=11, status=0, rd_addr_command=1.
3. EVP on an unset slot (command 0x02E0) -> no data pop, result=0, status=2.
4. Command 0x0F00 (bad opcode) through INSTR and OUTPUT -> status=1, no data pops.
5. STP with arg2=12 (0x010C) -> no pops, status=3; then RST 0x0300 and EVP on slot 0 -> status=2.
6. Drop rst mid-EVP evaluation -> all outputs 0 immediately; subsequent SETUP_INSTR firing works normally.
